// File: rtl/signed_cmp_swap_stage_if.sv
// Handshake bundle for signed_cmp_swap_stage: input pair, output pair, counter control.
// Optional out_eq member exists only when CSWAP_EQ_FLAG_EN is defined.
interface signed_cmp_swap_stage_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_min;
    logic [WIDTH-1:0] out_max;
    logic             out_lteq;
    logic             clr_cnt;
    logic [CNT_W-1:0] lteq_cnt;

`ifdef CSWAP_EQ_FLAG_EN
    logic             out_eq;

    modport master (
        output in_valid, in_a, in_b, out_ready, clr_cnt,
        input  in_ready, out_valid, out_min, out_max, out_lteq, out_eq, lteq_cnt
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready, clr_cnt,
        output in_ready, out_valid, out_min, out_max, out_lteq, out_eq, lteq_cnt
    );
`else
    modport master (
        output in_valid, in_a, in_b, out_ready, clr_cnt,
        input  in_ready, out_valid, out_min, out_max, out_lteq, lteq_cnt
    );
    modport slave (
        input  in_valid, in_a, in_b, out_ready, clr_cnt,
        output in_ready, out_valid, out_min, out_max, out_lteq, lteq_cnt
    );
`endif
endinterface

// File: rtl/signed_cmp_swap_stage.sv
// Two-stage signed compare-and-swap node emitting (min, max, a<=b) with a saturating a<=b counter.
// Optional CSWAP_EQ_FLAG_EN adds out_eq and restricts the counter to strict a<b transfers.
module signed_cmp_swap_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input logic                   clk,
    input logic                   rst,
    signed_cmp_swap_stage_if.slave bus
);

    logic                    s2_take;
    logic                    s1_take;
    logic                    in_fire;
    logic                    out_fire;
    logic                    cnt_inc;

    logic                    s1_valid_q, s1_valid_d;
    logic signed [WIDTH-1:0] s1_a_q, s1_a_d;
    logic signed [WIDTH-1:0] s1_b_q, s1_b_d;
    logic                    s1_lteq;

    logic                    s2_valid_q, s2_valid_d;
    logic        [WIDTH-1:0] s2_min_q, s2_min_d;
    logic        [WIDTH-1:0] s2_max_q, s2_max_d;
    logic                    s2_lteq_q, s2_lteq_d;

    logic        [CNT_W-1:0] cnt_q, cnt_d;

`ifdef CSWAP_EQ_FLAG_EN
    logic                    s1_eq;
    logic                    s2_eq_q, s2_eq_d;
`endif

    // Ready chain runs backwards from the output; in_valid never feeds in_ready.
    assign s2_take  = ~s2_valid_q | bus.out_ready;
    assign s1_take  = ~s1_valid_q | s2_take;
    assign in_fire  = bus.in_valid & s1_take;
    assign out_fire = s2_valid_q & bus.out_ready;

    // Both operands are declared signed, so this is a two's-complement compare.
    assign s1_lteq = (s1_a_q <= s1_b_q);

`ifdef CSWAP_EQ_FLAG_EN
    assign s1_eq   = (s1_a_q == s1_b_q);
    assign cnt_inc = out_fire & s2_lteq_q & ~s2_eq_q;
`else
    assign cnt_inc = out_fire & s2_lteq_q;
`endif

    always_comb begin
        // NOTE: every _d takes its _q as a default first, so no branch can infer a latch.
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_min_d   = s2_min_q;
        s2_max_d   = s2_max_q;
        s2_lteq_d  = s2_lteq_q;
`ifdef CSWAP_EQ_FLAG_EN
        s2_eq_d    = s2_eq_q;
`endif
        cnt_d      = cnt_q;

        if (s1_take) begin
            s1_valid_d = bus.in_valid;
        end
        if (in_fire) begin
            s1_a_d = bus.in_a;
            s1_b_d = bus.in_b;
        end

        if (s2_take) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_lteq_d = s1_lteq;
                s2_min_d  = s1_lteq ? s1_a_q : s1_b_q;
                s2_max_d  = s1_lteq ? s1_b_q : s1_a_q;
`ifdef CSWAP_EQ_FLAG_EN
                s2_eq_d   = s1_eq;
`endif
            end
        end

        if (bus.clr_cnt) begin
            cnt_d = '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data registers are reset as well so out_min/out_max read 0 after reset.
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_min_q   <= '0;
            s2_max_q   <= '0;
            s2_lteq_q  <= 1'b0;
`ifdef CSWAP_EQ_FLAG_EN
            s2_eq_q    <= 1'b0;
`endif
            cnt_q      <= '0;
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s2_valid_q <= s2_valid_d;
            s2_min_q   <= s2_min_d;
            s2_max_q   <= s2_max_d;
            s2_lteq_q  <= s2_lteq_d;
`ifdef CSWAP_EQ_FLAG_EN
            s2_eq_q    <= s2_eq_d;
`endif
            cnt_q      <= cnt_d;
        end
    end

    assign bus.in_ready  = s1_take;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_min   = s2_min_q;
    assign bus.out_max   = s2_max_q;
    assign bus.out_lteq  = s2_lteq_q;
`ifdef CSWAP_EQ_FLAG_EN
    assign bus.out_eq    = s2_eq_q;
`endif
    assign bus.lteq_cnt  = cnt_q;

endmodule

// File: doc/signed_cmp_swap_stage.md
Name: signed_cmp_swap_stage

Overview:
- Pipelined compare-and-swap stage built around the combinational signed less-than-or-equal comparator.
- Accepts a stream of signed operand pairs (a, b) over a valid/ready handshake.
- Emits the pair reordered as (min, max), plus the a<=b flag.
- Keeps a saturating count of a<=b results; used as the sorting/network node consuming the comparator's output.

Parameters:
- WIDTH, 32, operand width in bits, two's-complement signed; must be >= 2.
- CNT_W, 16, width of the saturating lteq counter; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  upstream has a valid operand pair.
- in_ready  out  1  stage accepts a pair this cycle.
- in_a  in  WIDTH  signed operand a.
- in_b  in  WIDTH  signed operand b.
- out_valid  out  1  output pair valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_min  out  WIDTH  the smaller of a and b (signed).
- out_max  out  WIDTH  the larger of a and b (signed).
- out_lteq  out  1  1 when a <= b (signed), i.e. no swap occurred.
- clr_cnt  in  1  synchronous clear of lteq_cnt.
- lteq_cnt  out  CNT_W  saturating count of completed transactions with out_lteq=1.

Behaviour:
- Reset: clk and rst as named above; reset is synchronous and active-high. All of the following are 0 after reset:
  - s1_valid, s2_valid, out_valid, out_min, out_max, out_lteq, lteq_cnt.
  - in_ready reads 1 in the first cycle after reset deasserts.
- Reset mid-operation: in-flight pairs are discarded with no output handshake, and the counter clears.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - Input data is sampled only on transfer.
  - Output data is held stable while out_valid=1 and out_ready=0.
- Pipeline, two register stages:
  - S1 registers a and b and computes lteq = (a <= b), signed compare on the full WIDTH, from the S1 registers.
  - S2 registers min/max/lteq:
    - lteq=1: min=a, max=b.
    - lteq=0: min=b, max=a.
  - S2 drives the out_* ports directly.
- Advance rules:
  - s2_take = ~s2_valid | out_ready.
  - s1_take = ~s1_valid | s2_take.
  - in_ready = s1_take. This is a combinational ready chain with no combinational path from in_valid to in_ready.
- Latency and throughput:
  - 2 cycles from input transfer to out_valid when there is no backpressure.
  - Throughput is 1 pair per cycle.
  - Bubbles collapse: an empty S2 accepts from S1 regardless of out_ready.
- Signed rules:
  - Bit WIDTH-1 is the sign.
  - Most negative value <= every value.
  - Maximum positive value <= only itself.
  - Equal operands: lteq=1, min=max=a.
- Counter:
  - On an output transfer with out_lteq=1, lteq_cnt increments.
  - It saturates at 2^CNT_W-1 and holds; no wrap.
  - clr_cnt=1 sets lteq_cnt to 0 next cycle, and wins over a simultaneous increment.
- Simultaneous in/out transfer when full: S2 unloads, S1 moves to S2 and the new pair enters S1 in the same cycle; no loss, no duplication.

Optional Feature:
- Macro: CSWAP_EQ_FLAG_EN.
- Defined:
  - Adds output port out_eq (1 bit), registered in S2 alongside out_lteq, equal to 1 when a == b. Reset value 0; held during stall.
  - lteq_cnt counts only strict a<b transfers (out_lteq & ~out_eq).
- Undefined:
  - No out_eq port.
  - lteq_cnt counts all transfers with out_lteq=1, including equality.

Test Plan:
- Reset then single pair a=-5 (0xFFFFFFFB), b=3, out_ready=1 -> exactly 2 cycles after transfer: out_valid=1, out_min=0xFFFFFFFB, out_max=3, out_lteq=1, lteq_cnt=1 one cycle after the output transfer.
- Boundaries a=0x7FFFFFFF, b=0x80000000 -> out_lteq=0, out_min=0x80000000, out_max=0x7FFFFFFF.
- Equal pair a=b=0x80000000 -> out_lteq=1, min=max=0x80000000; with CSWAP_EQ_FLAG_EN: out_eq=1 and lteq_cnt unchanged.
- Back-to-back stream of 4 pairs with out_ready=0 for 3 cycles after the first output:
  - in_ready drops after 2 pairs are held, and out_* stays stable throughout the stall.
  - After release, all 4 pairs emerge in order with no loss or duplication.
- CNT_W=2: 5 lteq transfers -> lteq_cnt 1,2,3,3,3.
- Counter clear: clr_cnt asserted in the same cycle as an lteq transfer -> lteq_cnt=0.
- Reset mid-operation: rst asserted with 2 pairs in flight -> next cycle out_valid=0, lteq_cnt=0, no output handshake for the dropped pairs.
